// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: single-outstanding req/ack fetcher feeding a
// PC-tagged prefetch FIFO, flushed on redirect with stale replies discarded.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_plus4
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t           state, state_nxt;
  logic [31:0]      fpc, fpc_nxt, addr_nxt, redir_pc;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic             push, pop;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];

  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

  // Only one request ever outstanding; DISCARD keeps it alive until the stale reply lands.
  always_comb begin
    state_nxt = state;
    fpc_nxt   = fpc;
    addr_nxt  = mem_addr;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          fpc_nxt = redir_pc;
        end else if (count < FULL) begin
          addr_nxt  = fpc;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          fpc_nxt   = redir_pc;
          state_nxt = mem_ack ? IDLE : DISCARD;
        end else if (mem_ack) begin
          push      = 1'b1;
          fpc_nxt   = fpc + 32'd4;
          state_nxt = IDLE;
        end
      end
      DISCARD: begin
        if (redirect_valid) fpc_nxt = redir_pc;
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mem_req    = (state == WAIT) || (state == DISCARD);
  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fpc      <= RESET_PC;
      mem_addr <= RESET_PC;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      state    <= state_nxt;
      fpc      <= fpc_nxt;
      mem_addr <= addr_nxt;
      if (redirect_valid) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (!push && pop) count <= count - CNT_W'(1);
      end
    end
  end

  // Storage needs no reset: every read is qualified by inst_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]   <= fpc;
      data_q[wr_ptr] <= mem_rdata;
    end
  end

  assign instruction = inst_valid ? data_q[rd_ptr] : 32'd0;
  assign inst_pc     = inst_valid ? pc_q[rd_ptr] : 32'd0;
  assign pc_plus4    = inst_valid ? (pc_q[rd_ptr] + 32'd4) : 32'd0;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed, table-driven bench for inst_fetch_queue: each vector gives the
// inputs for one cycle and the outputs expected at the start of that cycle.
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        ereq;
    logic [31:0] eaddr;
    logic        evalid;
    logic [31:0] einstr;
    logic [31:0] epc;
  } vec_t;

  vec_t  vecs[$];
  string scen;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .inst_pc(inst_pc), .pc_plus4(pc_plus4)
  );

  always #5 clk = ~clk;

  task automatic add(input logic redir, input logic [31:0] rpc, input logic ack,
                     input logic [31:0] rdata, input logic ready, input logic ereq,
                     input logic [31:0] eaddr, input logic evalid,
                     input logic [31:0] einstr, input logic [31:0] epc);
    vec_t v;
    v.redir = redir; v.rpc = rpc; v.ack = ack; v.rdata = rdata; v.ready = ready;
    v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.einstr = einstr; v.epc = epc;
    vecs.push_back(v);
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    mem_ack        = v.ack;
    mem_rdata      = v.rdata;
    inst_ready     = v.ready;
  endtask

  task automatic check_all(input string tag, input logic ereq, input logic [31:0] eaddr,
                           input logic evalid, input logic [31:0] einstr, input logic [31:0] epc);
    logic [31:0] eplus4;
    eplus4 = evalid ? epc + 32'd4 : 32'd0;
    check_output({tag, " mem_req"},     {31'd0, mem_req},    {31'd0, ereq});
    check_output({tag, " mem_addr"},    mem_addr,            eaddr);
    check_output({tag, " inst_valid"},  {31'd0, inst_valid}, {31'd0, evalid});
    check_output({tag, " instruction"}, instruction,         einstr);
    check_output({tag, " inst_pc"},     inst_pc,             epc);
    check_output({tag, " pc_plus4"},    pc_plus4,            eplus4);
  endtask

  // Called on a falling edge; leaves the bench on a falling edge.
  task automatic run_vectors();
    for (int i = 0; i < vecs.size(); i++) begin
      check_all($sformatf("%s c%0d", scen, i), vecs[i].ereq, vecs[i].eaddr,
                vecs[i].evalid, vecs[i].einstr, vecs[i].epc);
      apply_stimulus(vecs[i]);
      @(negedge clk);
    end
    vecs.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    mem_ack = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    mem_ack = 1'b0; mem_rdata = '0; inst_ready = 1'b0;
    #12;
    check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);

    // Ack one cycle after each request, consumer always ready.
    scen = "seq";
    do_reset();
    add(0,0,0,0,1,            0,32'h0, 0,0,0);
    add(0,0,0,0,1,            1,32'h0, 0,0,0);
    add(0,0,1,32'hA000_0000,1, 1,32'h0, 0,0,0);
    add(0,0,0,0,1,            0,32'h0, 1,32'hA000_0000,32'h0);
    add(0,0,0,0,1,            1,32'h4, 0,0,0);
    add(0,0,1,32'hA000_0004,1, 1,32'h4, 0,0,0);
    add(0,0,0,0,1,            0,32'h4, 1,32'hA000_0004,32'h4);
    add(0,0,0,0,1,            1,32'h8, 0,0,0);
    add(0,0,1,32'hA000_0008,1, 1,32'h8, 0,0,0);
    add(0,0,0,0,1,            0,32'h8, 1,32'hA000_0008,32'h8);
    add(0,0,0,0,1,            1,32'hC, 0,0,0);
    add(0,0,1,32'hA000_000C,1, 1,32'hC, 0,0,0);
    add(0,0,0,0,1,            0,32'hC, 1,32'hA000_000C,32'hC);
    add(0,0,0,0,0,            1,32'h10,0,0,0);
    run_vectors();

    // Fill to DEPTH with consumer stalled, then a single pop re-opens fetch.
    scen = "full";
    do_reset();
    add(0,0,0,0,0,            0,32'h0, 0,0,0);
    add(0,0,1,32'hB000_0000,0, 1,32'h0, 0,0,0);
    add(0,0,0,0,0,            0,32'h0, 1,32'hB000_0000,32'h0);
    add(0,0,1,32'hB000_0004,0, 1,32'h4, 1,32'hB000_0000,32'h0);
    add(0,0,0,0,0,            0,32'h4, 1,32'hB000_0000,32'h0);
    add(0,0,1,32'hB000_0008,0, 1,32'h8, 1,32'hB000_0000,32'h0);
    add(0,0,0,0,0,            0,32'h8, 1,32'hB000_0000,32'h0);
    add(0,0,1,32'hB000_000C,0, 1,32'hC, 1,32'hB000_0000,32'h0);
    add(0,0,0,0,0,            0,32'hC, 1,32'hB000_0000,32'h0);
    add(0,0,0,0,1,            0,32'hC, 1,32'hB000_0000,32'h0);
    add(0,0,0,0,0,            0,32'hC, 1,32'hB000_0004,32'h4);
    add(0,0,0,0,0,            1,32'h10,1,32'hB000_0004,32'h4);
    add(0,0,0,0,0,            1,32'h10,1,32'hB000_0004,32'h4);
    run_vectors();

    // Redirect while waiting: stale reply dropped, fetch resumes at 0x100.
    scen = "discard";
    do_reset();
    add(0,0,0,0,0,                     0,32'h0,  0,0,0);
    add(1,32'h103,0,0,0,               1,32'h0,  0,0,0);
    add(0,0,0,0,0,                     1,32'h0,  0,0,0);
    add(0,0,0,0,0,                     1,32'h0,  0,0,0);
    add(0,0,1,32'hDEAD_BEEF,0,         1,32'h0,  0,0,0);
    add(0,0,0,0,0,                     0,32'h0,  0,0,0);
    add(0,0,1,32'hC000_0100,0,         1,32'h100,0,0,0);
    add(0,0,0,0,0,                     0,32'h100,1,32'hC000_0100,32'h100);
    add(0,0,0,0,0,                     1,32'h104,1,32'hC000_0100,32'h100);
    run_vectors();

    // Redirect, ack and pop all in one cycle with two entries queued.
    scen = "redir_ack";
    do_reset();
    add(0,0,0,0,0,                     0,32'h0,  0,0,0);
    add(0,0,1,32'hD000_0000,0,         1,32'h0,  0,0,0);
    add(0,0,0,0,0,                     0,32'h0,  1,32'hD000_0000,32'h0);
    add(0,0,1,32'hD000_0004,0,         1,32'h4,  1,32'hD000_0000,32'h0);
    add(0,0,0,0,0,                     0,32'h4,  1,32'hD000_0000,32'h0);
    add(1,32'h200,1,32'hD000_0008,1,   1,32'h8,  1,32'hD000_0000,32'h0);
    add(0,0,0,0,0,                     0,32'h8,  0,0,0);
    add(0,0,1,32'hF000_0200,0,         1,32'h200,0,0,0);
    add(0,0,0,0,0,                     0,32'h200,1,32'hF000_0200,32'h200);
    run_vectors();

    // Fetch address and pc_plus4 wrap through 2^32.
    scen = "wrap";
    do_reset();
    add(1,32'hFFFF_FFF8,0,0,0,         0,32'h0,         0,0,0);
    add(0,0,0,0,0,                     0,32'h0,         0,0,0);
    add(0,0,1,32'hE000_0000,0,         1,32'hFFFF_FFF8, 0,0,0);
    add(0,0,0,0,0,                     0,32'hFFFF_FFF8, 1,32'hE000_0000,32'hFFFF_FFF8);
    add(0,0,1,32'hE000_0001,0,         1,32'hFFFF_FFFC, 1,32'hE000_0000,32'hFFFF_FFF8);
    add(0,0,0,0,1,                     0,32'hFFFF_FFFC, 1,32'hE000_0000,32'hFFFF_FFF8);
    add(0,0,1,32'hE000_0002,0,         1,32'h0,         1,32'hE000_0001,32'hFFFF_FFFC);
    add(0,0,0,0,1,                     0,32'h0,         1,32'hE000_0001,32'hFFFF_FFFC);
    add(0,0,0,0,0,                     1,32'h4,         1,32'hE000_0002,32'h0);
    run_vectors();

    // Reset mid-WAIT with three entries queued.
    scen = "midrst";
    do_reset();
    add(0,0,0,0,0,            0,32'h0, 0,0,0);
    add(0,0,1,32'hB000_0000,0, 1,32'h0, 0,0,0);
    add(0,0,0,0,0,            0,32'h0, 1,32'hB000_0000,32'h0);
    add(0,0,1,32'hB000_0004,0, 1,32'h4, 1,32'hB000_0000,32'h0);
    add(0,0,0,0,0,            0,32'h4, 1,32'hB000_0000,32'h0);
    add(0,0,1,32'hB000_0008,0, 1,32'h8, 1,32'hB000_0000,32'h0);
    add(0,0,0,0,0,            0,32'h8, 1,32'hB000_0000,32'h0);
    add(0,0,0,0,0,            1,32'hC, 1,32'hB000_0000,32'h0);
    run_vectors();
    check_all("midrst pre", 1'b1, 32'hC, 1'b1, 32'hB000_0000, 32'h0);
    #2 rst = 1'b0;
    #1 check_all("midrst async", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = 32'h5A5A_5A5A;
    rst       = 1'b1;
    @(negedge clk);
    check_all("midrst post1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    mem_ack = 1'b0;
    @(negedge clk);
    check_all("midrst post2", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
